// File: rtl/uart_tx_if.sv
// Message handshake and serial line between a uart_tx and its host.
interface uart_tx_if;
    localparam int unsigned DATA_W = 128;

    logic [DATA_W-1:0] DATA;
    logic              DATA_VALID;
    logic              BUSY;
    logic              DONE;
    logic              TX;

    modport master (output DATA, output DATA_VALID, input BUSY, input DONE, input TX);
    modport slave  (input DATA, input DATA_VALID, output BUSY, output DONE, output TX);
endinterface

// File: rtl/uart_tx.sv
// Serialises a 16-byte message as back-to-back 8N1 frames, byte 0 first, LSB first.
// Optional feature macro UART_TX_GAP_EN: GAP_BITS idle bit-times after every stop bit.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned GAP_BITS     = 1
) (
    input  logic     CLK,
    input  logic     RST_N,
    uart_tx_if.slave bus
);
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] BITS  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_TX_GAP_EN
    localparam logic [2:0] GAP   = 3'd4;
    localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
`else
    // GAP_BITS only shapes the frame when the gap is compiled in.
    if (GAP_BITS == 0) begin : g_gap_bits_unused
    end
`endif

    logic [1:0]        rst_sync_q;
    logic              run;
    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              byte_end;
`ifdef UART_TX_GAP_EN
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
`endif

    // Reset asserts immediately but only releases the FSM two edges after deassertion.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run     = rst_sync_q[1];
    assign bit_end = (bit_cnt_q == BIT_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        byte_end   = 1'b0;
`ifdef UART_TX_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif

        if (state_q != IDLE) begin
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (run && bus.DATA_VALID) begin
                    shift_d    = bus.DATA;
                    byte_cnt_d = '0;
                    bit_idx_d  = '0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = BITS;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            BITS: begin
                if (bit_end) begin
                    // Shifting after every data bit leaves the next byte's LSB at bit 0.
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
`ifdef UART_TX_GAP_EN
                    state_d   = GAP;
                    gap_cnt_d = '0;
                    tx_d      = 1'b1;
`else
                    byte_end  = 1'b1;
`endif
                end
            end
`ifdef UART_TX_GAP_EN
            GAP: begin
                if (bit_end) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        byte_end = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Byte 15 ends the message; the counter never wraps into a 17th byte.
        if (byte_end) begin
            if (byte_cnt_q == 4'd15) begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 4'd1;
                state_d    = START;
                tx_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef UART_TX_GAP_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    assign bus.TX   = tx_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a cycle-exact UART decoder pops expected bytes from a scoreboard.
module tb_uart_tx;
    localparam int CPB = 8;
    localparam int GAP = 2;
`ifdef UART_TX_GAP_EN
    localparam int BITS_PER_BYTE = 10 + GAP;
`else
    localparam int BITS_PER_BYTE = 10;
`endif
    localparam int MSG_CYC  = 16 * BITS_PER_BYTE * CPB;
    localparam int WAIT_MAX = MSG_CYC + 64;

    logic clk = 1'b0;
    logic rst_n;

    uart_tx_if bus();

    uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_bytes  = 0;
    int n_done   = 0;
    logic [7:0] sb[$];

    always @(negedge clk) if (bus.DONE === 1'b1) n_done++;

    // Decoder: a frame is 10 windows of exactly CPB cycles; TX must stay constant inside each.
    bit         mon_active = 0;
    int         mon_cnt    = 0;
    int         mon_bit    = 0;
    logic       mon_level;
    bit         mon_glitch;
    bit         mon_data_bad;
    logic [7:0] mon_byte;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mon_active = 0;
        end else begin
            if (!mon_active && bus.TX === 1'b0) begin
                mon_active   = 1;
                mon_cnt      = 0;
                mon_bit      = 0;
                mon_data_bad = 0;
            end
            if (mon_active) begin
                if (mon_cnt == 0) begin
                    mon_level  = bus.TX;
                    mon_glitch = 0;
                end else if (bus.TX !== mon_level) begin
                    mon_glitch = 1;
                end
                mon_cnt++;
                if (mon_cnt == CPB) begin
                    mon_cnt = 0;
                    if (mon_bit == 0) begin
                        n_checks++;
                        if (mon_level !== 1'b0 || mon_glitch) begin
                            n_fail++;
                            $display("FAIL start_bit: level=%b unstable=%0d, required level=0 held %0d cycles", mon_level, mon_glitch, CPB);
                        end
                    end else if (mon_bit <= 8) begin
                        mon_byte[3'(mon_bit - 1)] = mon_level;
                        if (mon_glitch) mon_data_bad = 1;
                    end else begin
                        n_checks++;
                        if (mon_level !== 1'b1 || mon_glitch) begin
                            n_fail++;
                            $display("FAIL stop_bit: level=%b unstable=%0d, required level=1 held %0d cycles", mon_level, mon_glitch, CPB);
                        end
                        n_checks++;
                        if (mon_data_bad) begin
                            n_fail++;
                            $display("FAIL data_bit_period: a data bit changed inside its %0d-cycle window, required stable", CPB);
                        end
                        n_checks++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_byte: got %02h, required no byte", mon_byte);
                        end else begin
                            mon_exp = sb.pop_front();
                            if (mon_byte !== mon_exp) begin
                                n_fail++;
                                $display("FAIL byte_value: got %02h, required %02h", mon_byte, mon_exp);
                            end
                        end
                        n_bytes++;
                        mon_active = 0;
                    end
                    mon_bit++;
                end
            end
        end
    end

    task automatic push_msg(input logic [127:0] d);
        for (int k = 0; k < 16; k++) sb.push_back(d[8*k +: 8]);
    endtask

    // Present d with a one-cycle DATA_VALID; returns at the negedge after acceptance.
    task automatic drive_msg(input logic [127:0] d);
        @(negedge clk);
        bus.DATA       = d;
        bus.DATA_VALID = 1'b1;
        push_msg(d);
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
    endtask

    // Counts negedges from now until DONE is seen, bounded by WAIT_MAX.
    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok     = 0;
        while (cycles < WAIT_MAX) begin
            if (bus.DONE === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst_n          = 1'b1;
        bus.DATA       = '0;
        bus.DATA_VALID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.TX !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", bus.TX); end
        n_checks++;
        if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.BUSY); end
        n_checks++;
        if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", bus.DONE); end
        repeat (3) @(negedge clk);
        rst_n          = 1'b1;
        bus.DATA_VALID = 1'b1;
        bus.DATA       = {4{32'hDEADBEEF}};
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        n_checks++;
        if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_release_sync: busy=%b on first edge after release, required 0", bus.BUSY); end
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.TX !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b tx=%b, required busy=0 tx=1", bus.BUSY, bus.TX);
        end
    endtask

    // One full message: acceptance, duration, DONE shape and byte count.
    task automatic test_message(input logic [127:0] d);
        int cyc;
        bit ok;
        int b0, d0;
        b0 = n_bytes;
        d0 = n_done;
        drive_msg(d);
        n_checks++;
        if (bus.BUSY !== 1'b1 || bus.TX !== 1'b0) begin
            n_fail++;
            $display("FAIL accept: busy=%b tx=%b, required busy=1 tx=0", bus.BUSY, bus.TX);
        end
        wait_done(cyc, ok);
        n_checks++;
        if (!ok || cyc != MSG_CYC) begin
            n_fail++;
            $display("FAIL msg_length: got %0d cycles (done seen=%0d), required %0d", cyc, ok, MSG_CYC);
        end
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.TX !== 1'b1) begin
            n_fail++;
            $display("FAIL done_cycle: busy=%b tx=%b, required busy=0 tx=1", bus.BUSY, bus.TX);
        end
        @(negedge clk);
        n_checks++;
        if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL done_width: done=%b one cycle later, required 0", bus.DONE); end
        n_checks++;
        if (n_bytes - b0 != 16 || n_done - d0 != 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL msg_totals: bytes=%0d dones=%0d left=%0d, required 16 1 0", n_bytes - b0, n_done - d0, sb.size());
        end
    endtask

    task automatic test_ignore_valid;
        int cyc;
        bit ok;
        int b0, d0;
        b0 = n_bytes;
        d0 = n_done;
        drive_msg(128'h00112233_44556677_8899AABB_CCDDEEFF);
        repeat (40 * CPB) @(negedge clk);
        bus.DATA       = 128'h5A5A5A5A_A5A5A5A5_12345678_9ABCDEF0;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        n_checks++;
        if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: busy=%b, required 1", bus.BUSY); end
        wait_done(cyc, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ignore_done: done not seen within %0d cycles, required one", WAIT_MAX); end
        repeat (3 * BITS_PER_BYTE * CPB) @(negedge clk);
        n_checks++;
        if (n_bytes - b0 != 16 || n_done - d0 != 1 || sb.size() != 0 || bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_totals: bytes=%0d dones=%0d left=%0d busy=%b, required 16 1 0 0", n_bytes - b0, n_done - d0, sb.size(), bus.BUSY);
        end
    endtask

    task automatic test_reset_abort;
        int d0;
        drive_msg({$urandom, $urandom, $urandom, $urandom});
        d0 = n_done;
        repeat ((7 * BITS_PER_BYTE + 4) * CPB + 3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.TX !== 1'b1 || bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: tx=%b busy=%b before any edge, required tx=1 busy=0", bus.TX, bus.BUSY);
        end
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BITS_PER_BYTE * CPB) @(negedge clk);
        n_checks++;
        if (n_done != d0 || bus.BUSY !== 1'b0 || bus.TX !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle: dones=%0d busy=%b tx=%b, required 0 0 1", n_done - d0, bus.BUSY, bus.TX);
        end
        test_message({16{8'hFF}});
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit ok;
        int b0, d0;
        b0 = n_bytes;
        d0 = n_done;
        @(negedge clk);
        bus.DATA       = 128'h0123456789ABCDEF_FEDCBA9876543210;
        bus.DATA_VALID = 1'b1;
        push_msg(bus.DATA);
        @(negedge clk);
        n_checks++;
        if (bus.BUSY !== 1'b1 || bus.TX !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept1: busy=%b tx=%b, required busy=1 tx=0", bus.BUSY, bus.TX);
        end
        bus.DATA = 128'hC3C3C3C3_3C3C3C3C_0F0F0F0F_F0F0F0F0;
        push_msg(bus.DATA);
        wait_done(cyc, ok);
        n_checks++;
        if (!ok || cyc != MSG_CYC) begin
            n_fail++;
            $display("FAIL b2b_length1: got %0d cycles (done seen=%0d), required %0d", cyc, ok, MSG_CYC);
        end
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        n_checks++;
        if (bus.BUSY !== 1'b1 || bus.TX !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b tx=%b cycle after done, required busy=1 tx=0", bus.BUSY, bus.TX);
        end
        wait_done(cyc, ok);
        n_checks++;
        if (!ok || cyc != MSG_CYC) begin
            n_fail++;
            $display("FAIL b2b_length2: got %0d cycles (done seen=%0d), required %0d", cyc, ok, MSG_CYC);
        end
        @(negedge clk);
        n_checks++;
        if (n_bytes - b0 != 32 || n_done - d0 != 2 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_totals: bytes=%0d dones=%0d left=%0d, required 32 2 0", n_bytes - b0, n_done - d0, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_message(128'h0F0E0D0C_0B0A0908_07060504_03020100);
        test_message({16{8'hAA}});
        test_ignore_valid();
        test_reset_abort();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
